// File: rtl/x_mem_seq.sv
// x_mem_seq: execute-stage memory access sequencer.
// Runs loads, stores and swaps (read then write to the same address) on the
// data-memory req/gnt/rvalid port and drives stall/release requests to the
// hazard unit so fetch/decode hold until the sequence completes.
// Optional watchdog: define X_MEM_SEQ_TIMEOUT_EN to abort an access that
// waits TIMEOUT_CYCLES cycles in any request/response state.
module x_mem_seq #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          x_valid_i,
  input  logic [1:0]    x_op_i,
  input  logic [AW-1:0] x_addr_i,
  input  logic [DW-1:0] x_wdata_i,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [AW-1:0] dmem_addr_o,
  output logic [DW-1:0] dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [DW-1:0] dmem_rdata_i,
  output logic [DW-1:0] x_rdata_o,
  output logic          x_done_o,
  output logic          x_stall_pc_o,
  output logic          x_stall_d_o,
  output logic          x_release_f_o,
  output logic          x_err_o
);

  typedef enum logic [2:0] {IDLE, REQ1, RSP1, REQ2, RSP2, DONE} state_e;
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  state_e        state, state_nx;
  op_e           op_q, op_in;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          accept;
  logic          in_wait;
  logic          timeout;
  logic          err_q;

  // Decode the incoming request; accept is gated by reset so every output
  // stays low while reset is asserted, even with a request presented.
  always_comb begin
    op_in   = op_e'(x_op_i);
    accept  = (state == IDLE) && rst_i && x_valid_i && (op_in != OP_NONE);
    in_wait = (state == REQ1) || (state == RSP1) || (state == REQ2) || (state == RSP2);
  end

`ifdef X_MEM_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  // Watchdog fires on the last permitted cycle of a waiting state.
  always_comb timeout = in_wait && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter restarts on every state change; err pulses the cycle after expiry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_nx != state) wd_cnt <= '0;
      else if (in_wait)      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // No watchdog: the error output is a constant 0 (parameter kept for interface compatibility).
  always_comb begin
    timeout = 1'b0;
    err_q   = (TIMEOUT_CYCLES < 0);
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; gnt outranks rvalid because rvalid is only looked at in RSP states.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept)        state_nx = REQ1;
      REQ1: if (dmem_gnt_i)    state_nx = RSP1;
      RSP1: if (dmem_rvalid_i) state_nx = (op_q == OP_SWAP) ? REQ2 : DONE;
      REQ2: if (dmem_gnt_i)    state_nx = RSP2;
      RSP2: if (dmem_rvalid_i) state_nx = DONE;
      DONE:                    state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
    if (timeout) state_nx = IDLE;
  end

  // Latch the operation on accept and capture read data from the first response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= x_addr_i;
        wdata_q <= x_wdata_i;
      end
      if ((state == RSP1) && dmem_rvalid_i && (op_q != OP_STORE)) rdata_q <= dmem_rdata_i;
    end
  end

  // Memory port and hazard-unit outputs decoded from state and latched op.
  always_comb begin
    dmem_req_o    = (state == REQ1) || (state == REQ2);
    dmem_we_o     = ((state == REQ1) && (op_q == OP_STORE)) || (state == REQ2);
    dmem_addr_o   = addr_q;
    dmem_wdata_o  = wdata_q;
    x_rdata_o     = rdata_q;
    x_done_o      = (state == DONE);
    x_stall_pc_o  = in_wait || accept;
    x_stall_d_o   = (in_wait && (op_q == OP_SWAP)) || (accept && (op_in == OP_SWAP));
    x_release_f_o = (state == DONE) || err_q;
    x_err_o       = err_q;
  end

endmodule
